// File: rtl/mult_share_pkg.sv
// Shared definitions for the multiplier-sharing controller: FSM state
// encoding and default sizing constants.
// Optional feature macro used by the controller: MULT_SHARE_CTRL_PERF_EN.
package mult_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_N      = 8;
  localparam int DEF_NREQ   = 4;
  localparam int DEF_SETTLE = 2;

endpackage

// File: rtl/multipliern.sv
// Purely combinational unsigned array multiplier: sum of shifted partial
// products, one row per multiplier bit.
module multipliern #(
  parameter int n = 8
) (
  input  logic [n-1:0]   m,
  input  logic [n-1:0]   q,
  output logic [2*n-1:0] s
);

  // accumulate one partial-product row per set bit of q
  always_comb begin
    s = '0;
    for (int i = 0; i < n; i++) begin
      if (q[i]) s = s + ({{n{1'b0}}, m} << i);
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester with req set,
// scanning upward from ptr and wrapping at NREQ-1, receives the grant.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx
);

  logic found;
  int   idx;

  // rotate the scan start to ptr and take the first active request
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        gnt[idx]   = 1'b1;
        gnt_idx    = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/mult_share_ctrl.sv
// Shares one multipliern instance among NREQ requesters. Requests are
// round-robin arbitrated in IDLE, operands are registered and held for
// SETTLE cycles in CALC, and the tagged product is held in DONE until taken.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid must not depend on ready, and the producer holds its
// payload until the transfer.
// Optional feature: define MULT_SHARE_CTRL_PERF_EN to add op_count, a
// wrapping 16-bit count of completed response transfers.
module mult_share_ctrl
  import mult_share_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int NREQ   = DEF_NREQ,
  parameter int SETTLE = DEF_SETTLE,
  parameter int IDW    = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_m,
  input  logic [NREQ*N-1:0] req_q,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [2*N-1:0]    rsp_s,
  output logic              busy,
`ifdef MULT_SHARE_CTRL_PERF_EN
  output logic [15:0]       op_count,
`endif
  output state_t            dbg_state
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_t          state;
  logic [IDW-1:0]  ptr;
  logic [N-1:0]    op_m;
  logic [N-1:0]    op_q;
  logic [CW-1:0]   cnt;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic [N-1:0]    sel_m;
  logic [N-1:0]    sel_q;
  logic [2*N-1:0]  prod;
  logic [IDW-1:0]  ptr_next;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // the array only ever sees the registered operands
  multipliern #(.n(N)) u_mul (
    .m (op_m),
    .q (op_q),
    .s (prod)
  );

  // only IDLE accepts, and nothing is accepted while reset is asserted
  assign req_ready = (state == IDLE && rst_n) ? gnt : '0;
  assign dbg_state = state;
  assign ptr_next  = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

  // pick the granted requester's operand slices
  always_comb begin
    sel_m = '0;
    sel_q = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt[k]) begin
        sel_m = req_m[k*N +: N];
        sel_q = req_q[k*N +: N];
      end
    end
  end

  // controller FSM with registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      op_m      <= '0;
      op_q      <= '0;
      cnt       <= '0;
      rsp_id    <= '0;
      rsp_s     <= '0;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            op_m   <= sel_m;
            op_q   <= sel_q;
            rsp_id <= gnt_idx;
            cnt    <= CW'(SETTLE - 1);
            ptr    <= ptr_next;
            busy   <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          if (cnt == '0) begin
            rsp_s     <= prod;
            rsp_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef MULT_SHARE_CTRL_PERF_EN
  // count completed response transfers, wrapping naturally at 16 bits
  always_ff @(posedge clk) begin
    if (!rst_n) op_count <= '0;
    else if (rsp_valid && rsp_ready) op_count <= op_count + 16'd1;
  end
`endif

endmodule

// File: doc/mult_share_ctrl.md
# mult_share_ctrl

Sequencing controller that shares one `multipliern` array-multiplier instance among `NREQ` requesters. It round-robin arbitrates valid/ready operand requests and registers the granted operands so the combinational array sees stable inputs. It holds them for a fixed settle window, then returns the `2N`-bit product tagged with the requester index. It sits between client datapaths and the shared multiplier.

## Interface
- `N`, default 8: operand width; product width is `2*N`.
- `NREQ`, default 4: number of requesters, ≥2.
- `SETTLE`, default 2: cycles the array multiplier is given to settle, ≥1.
- `IDW`, default `$clog2(NREQ)`: requester-id width.

Ports (`name  direction  width  meaning`):
- `clk  in  1`: single clock; all state on the rising edge.
- `rst_n  in  1`: synchronous, active-low reset.
- `req_valid  in  NREQ`: per-requester request valid.
- `req_ready  out  NREQ`: per-requester accept; at most one bit high.
- `req_m  in  NREQ*N`: multiplicand; requester `k` occupies `[k*N +: N]`.
- `req_q  in  NREQ*N`: multiplier, same packing.
- `rsp_valid  out  1`: product valid.
- `rsp_ready  in  1`: consumer accept.
- `rsp_id  out  IDW`: index of the requester that owns `rsp_s`.
- `rsp_s  out  2*N`: registered unsigned product.
- `busy  out  1`: high in CALC or DONE.

## Operation
- States:
  - IDLE: no operation held.
  - CALC: operands registered, settle counter running.
  - DONE: product held for the consumer.
- Arbitration:
  - Pointer `ptr` (IDW bits) selects the highest-priority index.
  - Grant `g` is the first index with `req_valid` set, scanning `ptr, ptr+1, …` and wrapping `NREQ-1 → 0`.
- Handshakes:
  - IDLE: `req_ready[g]=1` combinationally when any `req_valid` is set; all other bits are 0. In CALC and DONE all bits are 0.
  - A request transfer is `req_valid[k] & req_ready[k]`.
  - A response transfer is `rsp_valid & rsp_ready`.
- IDLE with a request transfer:
  - Capture `req_m`/`req_q` slice `g` into operand registers; capture `g` into the id register.
  - Load the settle counter with `SETTLE-1`.
  - Set `ptr = (g+1) mod NREQ`.
  - Go to CALC.
- CALC:
  - Counter decrements each cycle.
  - On the cycle the counter is 0: register the multiplier output into `rsp_s`, set `rsp_valid`, go to DONE.
- DONE:
  - `rsp_s`, `rsp_id` and `rsp_valid` are held stable until the response transfer.
  - On the transfer: clear `rsp_valid`, go to IDLE. `rsp_s` keeps its last value.
- Arithmetic: unsigned, full `2*N`-bit product; no truncation or overflow.
- Requesters must not make `req_valid` depend on `req_ready`. Operands are sampled only on the transfer cycle.
- Reset (any state, including mid-CALC or DONE):
  - Go to IDLE; the in-flight operation is discarded with no response.
  - `ptr=0`; `rsp_valid=0`; `rsp_s=0`; `rsp_id=0`; operand registers 0; counter 0; `busy=0`.
  - `req_ready=0` during reset.

## Timing
- Request transfer at cycle T; CALC spans T+1 … T+SETTLE; `rsp_valid` is high from T+SETTLE+1.
- Minimum issue interval: `SETTLE+2` cycles (IDLE, `SETTLE` CALC cycles, one DONE cycle with `rsp_ready=1`).
- A response transfer in DONE at cycle D allows the next request transfer no earlier than D+1; there is no overlap.
- `req_ready` is combinational from `req_valid`, state and `ptr`. All other outputs are registered.
- Simultaneous valids: exactly one grant per IDLE cycle; the others wait with no loss.
- A requester that drops `req_valid` before its grant is simply skipped.

## Configuration
- Macro `MULT_SHARE_CTRL_PERF_EN`.
- Defined:
  - Adds output `op_count  out  16`, the number of completed response transfers.
  - It increments on each response transfer, wraps `16'hFFFF → 0`, and is reset to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package `mult_share_pkg`:
  - State enum `IDLE/CALC/DONE`.
  - Default constants for `N`, `NREQ` and `SETTLE`.
- Sub-module `rr_arbiter` (parameter `NREQ`):
  - Purely combinational: `req`, `ptr` in; one-hot `gnt` and `gnt_idx` out.
- The controller instantiates `rr_arbiter` and the existing `multipliern` (`n=N`), driven from the operand registers.

## Test plan
- Reset with all requests active: during and after `rst_n=0`, `req_ready=0`, `rsp_valid=0`, `rsp_s=0`, `busy=0`. The first grant after release is index 0.
- Single request, `N=8`, `SETTLE=2`: port 2 sends `m=8'hFF`, `q=8'hFF` at cycle T → `rsp_valid` rises at T+3 with `rsp_s=16'hFE01`, `rsp_id=2`.
- All four `req_valid` held high with `rsp_ready=1`: grant order is 0,1,2,3,0, and each product matches its operands.
- Backpressure: `rsp_ready=0` for 5 cycles in DONE → `rsp_valid`/`rsp_s`/`rsp_id` stable and `req_ready=0` throughout. The next grant comes the cycle after `rsp_ready` rises.
- Reset pulse during CALC → no response for the aborted operation; `ptr=0`; the next operation completes correctly.
- With `MULT_SHARE_CTRL_PERF_EN`: 3 operations give `op_count=3`; preloaded near wrap, `16'hFFFF` then one response gives 0.
